// File: rtl/di_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | di_master_arbiter: two-master round-robin owner of the Device Interface  |
// | with registered strobes, response steering and a stall watchdog.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module di_master_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic        if_clock,
   input  logic        resetb,
   input  logic        m0_req,
   output logic        m0_gnt,
   input  logic [15:0] m0_ep_addr,
   input  logic [15:0] m0_reg_addr,
   input  logic [15:0] m0_data_in,
   input  logic        m0_write,
   input  logic        m0_read,
   output logic [15:0] m0_data_out,
   output logic        m0_rd_ready,
   output logic        m0_wr_ready,
   input  logic        m1_req,
   output logic        m1_gnt,
   input  logic [15:0] m1_ep_addr,
   input  logic [15:0] m1_reg_addr,
   input  logic [15:0] m1_data_in,
   input  logic        m1_write,
   input  logic        m1_read,
   output logic [15:0] m1_data_out,
   output logic        m1_rd_ready,
   output logic        m1_wr_ready,
   output logic [15:0] diEpAddr,
   output logic [15:0] diRegAddr,
   output logic [15:0] diRegDataIn,
   output logic        diWrite,
   output logic        diRead,
   input  logic [15:0] diRegDataOut,
   input  logic        rd_ready,
   input  logic        wr_ready,
   output logic        timeout_err,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      TURN = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_LIMIT   = CNT_W'(TIMEOUT - 1);
   localparam bit               C_WDOG_EN = (TIMEOUT != 0);

   state_t           r_state;
   logic             r_last_served;
   logic             r_revoked0;
   logic             r_revoked1;
   logic [CNT_W-1:0] r_wdog;

   logic        w_own0, w_own1;
   logic        w_req, w_write, w_read, w_strobe, w_expire;
   logic [15:0] w_ep, w_reg, w_data;
   logic        w_elig0, w_elig1, w_pick1;

   assign w_own0   = (r_state == OWN0);
   assign w_own1   = (r_state == OWN1);

   // Current owner's request bundle; only meaningful in OWN0/OWN1.
   assign w_req    = w_own1 ? m1_req      : m0_req;
   assign w_write  = w_own1 ? m1_write    : m0_write;
   assign w_read   = w_own1 ? m1_read     : m0_read;
   assign w_ep     = w_own1 ? m1_ep_addr  : m0_ep_addr;
   assign w_reg    = w_own1 ? m1_reg_addr : m0_reg_addr;
   assign w_data   = w_own1 ? m1_data_in  : m0_data_in;
   assign w_strobe = w_write | w_read;
   assign w_expire = C_WDOG_EN && !w_strobe && (r_wdog == C_LIMIT);

   assign w_elig0  = m0_req & ~r_revoked0;
   assign w_elig1  = m1_req & ~r_revoked1;
   assign w_pick1  = w_elig1 & (~w_elig0 | ~r_last_served);

   assign m0_data_out = w_own0 ? diRegDataOut : 16'h0000;
   assign m0_rd_ready = w_own0 & rd_ready;
   assign m0_wr_ready = w_own0 & wr_ready;
   assign m1_data_out = w_own1 ? diRegDataOut : 16'h0000;
   assign m1_rd_ready = w_own1 & rd_ready;
   assign m1_wr_ready = w_own1 & wr_ready;

   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         r_state       <= IDLE;
         r_last_served <= 1'b1;
         r_revoked0    <= 1'b0;
         r_revoked1    <= 1'b0;
         r_wdog        <= '0;
         m0_gnt        <= 1'b0;
         m1_gnt        <= 1'b0;
         owner         <= 2'b00;
         diEpAddr      <= 16'h0000;
         diRegAddr     <= 16'h0000;
         diRegDataIn   <= 16'h0000;
         diWrite       <= 1'b0;
         diRead        <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         diWrite     <= 1'b0;
         diRead      <= 1'b0;
         timeout_err <= 1'b0;
         if (!m0_req) r_revoked0 <= 1'b0;
         if (!m1_req) r_revoked1 <= 1'b0;

         case (r_state)
            IDLE: begin
               r_wdog <= '0;
               if (w_elig0 | w_elig1) begin
                  r_state <= w_pick1 ? OWN1 : OWN0;
                  m0_gnt  <= ~w_pick1;
                  m1_gnt  <= w_pick1;
                  owner   <= w_pick1 ? 2'b10 : 2'b01;
               end
            end
            OWN0, OWN1: begin
               diEpAddr    <= w_ep;
               diRegAddr   <= w_reg;
               diRegDataIn <= w_data;
               if (!w_req) begin
                  // Release wins over a same-cycle strobe or watchdog expiry.
                  r_state       <= TURN;
                  m0_gnt        <= 1'b0;
                  m1_gnt        <= 1'b0;
                  owner         <= 2'b00;
                  r_last_served <= w_own1;
               end else begin
                  diWrite <= w_write;
                  diRead  <= w_read;
                  if (w_expire) begin
                     r_state       <= TURN;
                     m0_gnt        <= 1'b0;
                     m1_gnt        <= 1'b0;
                     owner         <= 2'b00;
                     r_last_served <= w_own1;
                     timeout_err   <= 1'b1;
                     if (w_own1) r_revoked1 <= 1'b1;
                     else        r_revoked0 <= 1'b1;
                  end else if (w_strobe) begin
                     r_wdog <= '0;
                  end else if (r_wdog != {CNT_W{1'b1}}) begin
                     r_wdog <= r_wdog + 1'b1;
                  end
               end
            end
            TURN:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_di_master_arbiter.sv
`default_nettype none
// Bench for di_master_arbiter: directed table, multi-cycle corner cases and
// randomized traffic checked against an ownership-level reference model.
module tb_di_master_arbiter;
   localparam int TIMEOUT = 8;

   logic        if_clock = 1'b0;
   logic        resetb   = 1'b0;
   logic        req[2], wr[2], rd[2];
   logic [15:0] ep[2], ra[2], din[2];
   logic [15:0] di_dout;
   logic        rd_ready, wr_ready;

   logic        m0_gnt, m1_gnt, m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready;
   logic [15:0] m0_data_out, m1_data_out, diEpAddr, diRegAddr, diRegDataIn;
   logic        diWrite, diRead, timeout_err;
   logic [1:0]  owner;

   always #5 if_clock = ~if_clock;

   di_master_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
      .if_clock(if_clock), .resetb(resetb),
      .m0_req(req[0]), .m0_gnt(m0_gnt), .m0_ep_addr(ep[0]), .m0_reg_addr(ra[0]),
      .m0_data_in(din[0]), .m0_write(wr[0]), .m0_read(rd[0]),
      .m0_data_out(m0_data_out), .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready),
      .m1_req(req[1]), .m1_gnt(m1_gnt), .m1_ep_addr(ep[1]), .m1_reg_addr(ra[1]),
      .m1_data_in(din[1]), .m1_write(wr[1]), .m1_read(rd[1]),
      .m1_data_out(m1_data_out), .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready),
      .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
      .diWrite(diWrite), .diRead(diRead), .diRegDataOut(di_dout),
      .rd_ready(rd_ready), .wr_ready(wr_ready),
      .timeout_err(timeout_err), .owner(owner)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the bus (-1 none), handoff bubble, fairness, stalls.
   int          m_own;
   bit          m_turn, m_last;
   bit          m_rev[2];
   int          m_idle;
   logic [15:0] e_ep, e_ra, e_din;
   logic        e_wr, e_rd, e_terr;

   task automatic model_reset();
      m_own = -1; m_turn = 0; m_last = 1; m_rev[0] = 0; m_rev[1] = 0; m_idle = 0;
      e_ep = 0; e_ra = 0; e_din = 0; e_wr = 0; e_rd = 0; e_terr = 0;
   endtask

   task automatic model_step();
      bit el0, el1;
      int n;
      if (!resetb) begin
         model_reset();
         return;
      end
      e_wr = 0; e_rd = 0; e_terr = 0;
      el0 = req[0] && !m_rev[0];
      el1 = req[1] && !m_rev[1];
      if (m_turn) begin
         m_turn = 0;
      end else if (m_own < 0) begin
         if (el0 && el1)  m_own = m_last ? 0 : 1;
         else if (el0)    m_own = 0;
         else if (el1)    m_own = 1;
         m_idle = 0;
      end else begin
         n = m_own;
         e_ep = ep[n]; e_ra = ra[n]; e_din = din[n];
         if (!req[n]) begin
            m_last = (n == 1); m_own = -1; m_turn = 1;
         end else begin
            e_wr = wr[n]; e_rd = rd[n];
            if (wr[n] || rd[n]) m_idle = 0;
            else begin
               m_idle++;
               if (m_idle == TIMEOUT) begin
                  e_terr = 1; m_rev[n] = 1; m_last = (n == 1); m_own = -1; m_turn = 1;
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) if (!req[k]) m_rev[k] = 0;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 50)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [1:0] e_owner;
      e_owner = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
      chk("m0_gnt", m0_gnt, m_own == 0);
      chk("m1_gnt", m1_gnt, m_own == 1);
      chk("owner", owner, e_owner);
      chk("diWrite", diWrite, e_wr);
      chk("diRead", diRead, e_rd);
      chk("timeout_err", timeout_err, e_terr);
      chk("diEpAddr", diEpAddr, e_ep);
      chk("diRegAddr", diRegAddr, e_ra);
      chk("diRegDataIn", diRegDataIn, e_din);
      chk("m0_data_out", m0_data_out, (m_own == 0) ? di_dout : 16'h0);
      chk("m1_data_out", m1_data_out, (m_own == 1) ? di_dout : 16'h0);
      chk("m0_rd_ready", m0_rd_ready, (m_own == 0) && rd_ready);
      chk("m1_rd_ready", m1_rd_ready, (m_own == 1) && rd_ready);
      chk("m0_wr_ready", m0_wr_ready, (m_own == 0) && wr_ready);
      chk("m1_wr_ready", m1_wr_ready, (m_own == 1) && wr_ready);
   endtask

   task automatic cycle();
      @(posedge if_clock);
      model_step();
      #1;
      check_model();
   endtask

   typedef struct {
      logic r0, r1, w0, rd0, w1, rd1;
      logic g0, g1;
      logic [1:0] own;
      logic dw, dr;
   } vec_t;

   vec_t tv[11];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulse_at, pulses, regrant, bad;
      bit got;
      tv[0]  = '{1,1,0,0,0,0, 1,0,2'b01, 0,0};
      tv[1]  = '{1,1,1,0,1,0, 1,0,2'b01, 1,0};
      tv[2]  = '{1,1,0,0,0,0, 1,0,2'b01, 0,0};
      tv[3]  = '{0,1,0,1,0,0, 0,0,2'b00, 0,0};
      tv[4]  = '{1,1,0,0,0,0, 0,0,2'b00, 0,0};
      tv[5]  = '{1,1,0,0,0,0, 0,1,2'b10, 0,0};
      tv[6]  = '{1,1,1,0,0,1, 0,1,2'b10, 0,1};
      tv[7]  = '{1,1,0,0,0,0, 0,1,2'b10, 0,0};
      tv[8]  = '{1,0,0,0,0,0, 0,0,2'b00, 0,0};
      tv[9]  = '{1,0,0,0,0,0, 0,0,2'b00, 0,0};
      tv[10] = '{1,0,0,0,0,0, 1,0,2'b01, 0,0};

      for (int k = 0; k < 2; k++) begin
         req[k] = 0; wr[k] = 0; rd[k] = 0;
      end
      ep[0] = 16'h0003; ra[0] = 16'h0010; din[0] = 16'hBEEF;
      ep[1] = 16'h0007; ra[1] = 16'h0020; din[1] = 16'h5555;
      di_dout = 16'h1234; rd_ready = 1; wr_ready = 1;
      model_reset();

      repeat (2) cycle();
      resetb = 1;

      for (int i = 0; i < 11; i++) begin
         req[0] = tv[i].r0; req[1] = tv[i].r1;
         wr[0] = tv[i].w0; rd[0] = tv[i].rd0; wr[1] = tv[i].w1; rd[1] = tv[i].rd1;
         cycle();
         chk($sformatf("tbl%0d_g0", i), m0_gnt, tv[i].g0);
         chk($sformatf("tbl%0d_g1", i), m1_gnt, tv[i].g1);
         chk($sformatf("tbl%0d_owner", i), owner, tv[i].own);
         chk($sformatf("tbl%0d_dw", i), diWrite, tv[i].dw);
         chk($sformatf("tbl%0d_dr", i), diRead, tv[i].dr);
         if (i == 1) begin
            chk("first_write_ep", diEpAddr, 16'h0003);
            chk("first_write_reg", diRegAddr, 16'h0010);
            chk("first_write_data", diRegDataIn, 16'hBEEF);
         end
         if (i == 6) begin
            chk("m1_read_data", m1_data_out, 16'h1234);
            chk("m0_read_data_masked", m0_data_out, 16'h0000);
         end
      end

      // Watchdog: m0 owns and stalls with req held high.
      req[0] = 1; req[1] = 0; wr[0] = 0; rd[0] = 0; wr[1] = 0; rd[1] = 0;
      pulse_at = -1; pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (timeout_err) begin
            pulses++;
            if (pulse_at < 0) pulse_at = k;
         end
      end
      chk("wdog_pulse_cycle", pulse_at[15:0], 16'd8);
      chk("wdog_pulse_count", pulses[15:0], 16'd1);
      chk("gnt_after_revoke", m0_gnt, 0);
      regrant = 0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (m0_gnt) regrant++;
      end
      chk("no_regrant_while_held", regrant[15:0], 16'd0);
      req[0] = 0;
      cycle();
      req[0] = 1;
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
         cycle();
         if (m0_gnt) got = 1;
      end
      chk("regrant_after_drop", got, 1);

      // Reset in the middle of an m1 write burst.
      req[0] = 0; req[1] = 1;
      got = 0;
      for (int k = 0; k < 6 && !got; k++) begin
         cycle();
         if (m1_gnt) got = 1;
      end
      chk("m1_granted", got, 1);
      wr[1] = 1; ep[1] = 16'h00A5; ra[1] = 16'h0042; din[1] = 16'hCAFE;
      repeat (2) cycle();
      #2;
      resetb = 0;
      #1;
      model_reset();
      check_model();
      chk("async_rst_diWrite", diWrite, 0);
      chk("async_rst_diEpAddr", diEpAddr, 16'h0000);
      repeat (2) cycle();
      resetb = 1;
      got = 0; bad = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (diWrite && !got) bad++;
         if (m1_gnt) got = 1;
      end
      chk("no_write_before_regrant", bad[15:0], 16'd0);
      chk("m1_regranted_after_reset", got, 1);

      // Read strobe in the same cycle as req fall.
      wr[1] = 0; req[1] = 0; req[0] = 1;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         cycle();
         if (m0_gnt) got = 1;
      end
      chk("m0_granted_for_fall", got, 1);
      req[0] = 0; rd[0] = 1;
      cycle();
      chk("fall_strobe_dropped", diRead, 0);
      chk("fall_owner_none", owner, 2'b00);
      rd[0] = 0;
      cycle();
      chk("turn_bubble_no_grant", owner, 2'b00);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
            wr[k]  = ($urandom_range(0, 7) == 0);
            rd[k]  = ($urandom_range(0, 7) == 0);
            ep[k]  = 16'($urandom);
            ra[k]  = 16'($urandom);
            din[k] = 16'($urandom);
         end
         di_dout  = 16'($urandom);
         rd_ready = 1'($urandom);
         wr_ready = 1'($urandom);
         resetb   = ($urandom_range(0, 499) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/di_master_arbiter.md
Name: di_master_arbiter

Overview:
- Shares the single Device Interface (endpoint/register address, write data, read/write strobes, ready flags, read data) between two masters.
- Master 0 is the host-side register engine driven from the GPIF host interface. Master 1 is an on-chip sequencer, for example a power-up register loader.
- Grants are exclusive and held for a whole burst. Strobes are registered toward the endpoints. Responses are steered back to the owner only.
- A watchdog revokes a grant if the owner stalls.

Parameters:
- TIMEOUT, 1024: idle cycles (no strobe from owner) before forced revoke; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; must hold TIMEOUT.

Ports:
- if_clock  in  1  interface clock, all logic on rising edge
- resetb  in  1  asynchronous, active-low reset
- mN_req  in  1  master N (N=0,1) requests ownership; held for the whole burst
- mN_gnt  out  1  master N owns the Device Interface (registered)
- mN_ep_addr  in  16  master N endpoint address
- mN_reg_addr  in  16  master N register address
- mN_data_in  in  16  master N write data
- mN_write  in  1  master N write strobe, 1 cycle per word
- mN_read  in  1  master N read strobe, 1 cycle per word
- mN_data_out  out  16  read data to master N
- mN_rd_ready  out  1  rd_ready steered to master N
- mN_wr_ready  out  1  wr_ready steered to master N
- diEpAddr  out  16  endpoint address to endpoints
- diRegAddr  out  16  register address to endpoints
- diRegDataIn  out  16  write data to endpoints
- diWrite  out  1  write strobe to endpoints
- diRead  out  1  read strobe to endpoints
- diRegDataOut  in  16  read data from endpoints
- rd_ready  in  1  endpoint read-ready
- wr_ready  in  1  endpoint write-ready
- timeout_err  out  1  one-cycle pulse on watchdog revoke
- owner  out  2  00 none, 01 master 0, 10 master 1 (debug)

Behaviour:
- Reset (async, resetb low): state IDLE; all outputs 0, including addresses, data, gnt, timeout_err and owner; last_served=1, so master 0 wins the first tie; both revoked flags clear.
- FSM states:
  - IDLE: no owner.
  - OWN0, OWN1: master 0 or master 1 owns the interface.
  - TURN: one-cycle handoff bubble with no owner.
- IDLE:
  - Eligible requester = mN_req high and revokedN clear.
  - One eligible requester: go to OWNN.
  - Both eligible: grant the master != last_served (round robin).
  - None eligible: stay in IDLE.
- mN_gnt and owner are registered and become 1 in the first cycle of OWNN, i.e. 1 cycle after the IDLE decision. Worst-case grant latency from req rise is 2 cycles, or 4 if arriving during OWN/TURN release.
- OWNN forwarding:
  - Each cycle, diEpAddr/diRegAddr/diRegDataIn <= mN values and diWrite/diRead <= mN_write/mN_read. Latency is 1 cycle.
  - Strobes are forwarded only while mN_req=1.
  - The non-owner's strobes are ignored entirely.
- Response steering (combinational):
  - Owner: mN_data_out=diRegDataOut, mN_rd_ready=rd_ready, mN_wr_ready=wr_ready.
  - Non-owner: all three read 0.
  - In IDLE and TURN, both masters read 0.
- Release: in OWNN, mN_req=0 -> TURN; set last_served=N; drop gnt the same edge.
- TURN: diWrite=diRead=0; addresses and data hold their last values; next state IDLE unconditionally.
- Addresses and data are never cleared outside reset; they hold the last owner's values.
- Watchdog:
  - Counter cleared on entry to OWNN and on any cycle with mN_write|mN_read.
  - Otherwise the counter increments, saturating.
  - When the counter reaches TIMEOUT (TIMEOUT!=0): go to TURN, set revokedN, pulse timeout_err for 1 cycle, set last_served=N.
- revokedN clears in any cycle where mN_req=0. A revoked master must drop req for at least 1 cycle before it is eligible again.
- Simultaneous events:
  - A strobe in the same cycle as req fall is not forwarded.
  - req fall in the same cycle as watchdog expiry is treated as a normal release: no timeout_err, revoked not set.
- A strobe issued by a master without gnt is dropped silently.
- Reset asserted mid-burst: immediate return to the reset values above; no strobe is emitted after resetb falls.

Test Plan:
- Reset, then m0_req=1 alone, m0 writes ep=0x0003, reg=0x0010, data=0xBEEF → m0_gnt rises 1 cycle after the decision; diWrite pulses 1 cycle after m0_write, with diEpAddr=0x0003, diRegAddr=0x0010, diRegDataIn=0xBEEF; m1_wr_ready=0 throughout.
- Both req rise the same cycle after reset → master 0 granted. m0 releases; TURN lasts 1 cycle with diRead=diWrite=0. Both requesting again → master 1 granted (round robin).
- m1 owns the interface; m1 reads with diRegDataOut=0x1234 and rd_ready=1 → m1_data_out=0x1234, m1_rd_ready=1; m0_data_out=0 and m0_rd_ready=0; m0 strobes produce no diRead/diWrite.
- TIMEOUT=8; m0 owns and holds req with no strobes → revoke on the 8th idle cycle: timeout_err pulses once, m0_gnt=0. m0 keeps req high → never regranted. m0 drops req 1 cycle and raises it → granted again.
- resetb pulsed low during an m1 write burst → all outputs 0 asynchronously; after release, m1 must win arbitration anew before any diWrite is emitted.
- m0 strobes diRead in the same cycle m0_req falls → no diRead emitted; state goes OWN0 → TURN → IDLE.
